// File: rtl/controller_sequencer.sv
// controller_sequencer: SAP-1 controller-sequencer.
//
// A six-state one-hot ring counter (T1..T6) steps through the fetch cycle
// (T1..T3). It then decodes the IR opcode nibble into the execute-phase
// control word (T4..T6). HLT freezes the counter in T4 until clr.
// The counter advances on the falling edge of clk. This gives the
// datapath a control word that has been stable for half a cycle at each
// rising edge.
//
// Optional feature, enabled by defining CTRL_EARLY_RETURN_EN:
//   the counter returns to T1 right after the last active execute state.
//   LDA takes 5 states, OUT and NOP take 4, ADD and SUB take 6.
//
// Ports:
//   clk     in   system clock (state changes on the falling edge)
//   clr     in   asynchronous active-high reset
//   opcode  in   [3:0] IR upper nibble, used only in T4..T6
//   Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo
//           out  active-high control strobes, combinational
//   hlt     out  machine halted (sticky until clr)
//   tstate  out  [5:0] one-hot T-state, bit 0 = T1
module controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] opcode,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm,
    output logic       CE,
    output logic       Li,
    output logic       Ei,
    output logic       La,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb,
    output logic       Lo,
    output logic       hlt,
    output logic [5:0] tstate
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    tstate_e state_q, state_d;
    logic    halt_q, halt_d;

    logic is_lda, is_add, is_sub, is_out, halt_now;
    logic early_t4, early_t5;

    assign is_lda   = (opcode == OP_LDA);
    assign is_add   = (opcode == OP_ADD);
    assign is_sub   = (opcode == OP_SUB);
    assign is_out   = (opcode == OP_OUT);
    assign halt_now = (state_q == T4) && (opcode == OP_HLT);

`ifdef CTRL_EARLY_RETURN_EN
    // OUT and NOP have no work after T4. LDA has no work after T5.
    // HLT never reaches the early-return decision because halting takes priority.
    assign early_t4 = !(is_lda || is_add || is_sub);
    assign early_t5 = is_lda;
`else
    assign early_t4 = 1'b0;
    assign early_t5 = 1'b0;
`endif

    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            state_q <= T1;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        halt_d  = halt_q || halt_now;
        state_d = T1;
        if (halt_d) begin
            state_d = state_q;
        end else begin
            case (state_q)
                T1:      state_d = T2;
                T2:      state_d = T3;
                T3:      state_d = T4;
                T4:      state_d = early_t4 ? T1 : T5;
                T5:      state_d = early_t5 ? T1 : T6;
                T6:      state_d = T1;
                default: state_d = T1; // illegal encodings recover to T1
            endcase
        end
    end

    always_comb begin
        Cp = 1'b0;
        Ep = 1'b0;
        Lm = 1'b0;
        CE = 1'b0;
        Li = 1'b0;
        Ei = 1'b0;
        La = 1'b0;
        Ea = 1'b0;
        Su = 1'b0;
        Eu = 1'b0;
        Lb = 1'b0;
        Lo = 1'b0;
        // hlt is raised combinationally on T4 entry. halt_q keeps it raised
        // even if opcode changes later.
        hlt    = !clr && (halt_q || halt_now);
        tstate = state_q;
        if (!clr && !hlt) begin
            case (state_q)
                T1: begin
                    Ep = 1'b1;
                    Lm = 1'b1;
                end
                T2: Cp = 1'b1;
                T3: begin
                    CE = 1'b1;
                    Li = 1'b1;
                end
                T4: begin
                    if (is_lda || is_add || is_sub) begin
                        Ei = 1'b1;
                        Lm = 1'b1;
                    end else if (is_out) begin
                        Ea = 1'b1;
                        Lo = 1'b1;
                    end
                end
                T5: begin
                    if (is_lda) begin
                        CE = 1'b1;
                        La = 1'b1;
                    end else if (is_add || is_sub) begin
                        CE = 1'b1;
                        Lb = 1'b1;
                    end
                end
                T6: begin
                    if (is_add || is_sub) begin
                        Eu = 1'b1;
                        La = 1'b1;
                        Su = is_sub;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controller_sequencer.sv
module tb_controller_sequencer;

    logic       clk;
    logic       clr;
    logic [3:0] opcode;
    logic       Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, hlt;
    logic [5:0] tstate;
    logic [11:0] ctrl_obs;

    int checks   = 0;
    int failures = 0;

    // Reference model: current T-state number (1..6) and halted flag.
    int t_m;
    bit halted_m;
    int cp_seen;

    // Control word bit positions, {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}.
    localparam int CP = 11, EP = 10, LM = 9, CEB = 8, LI = 7, EI = 6;
    localparam int LA = 5, EA = 4, SU = 3, EU = 2, LB = 1, LO = 0;

    controller_sequencer dut (
        .clk    (clk),
        .clr    (clr),
        .opcode (opcode),
        .Cp     (Cp),
        .Ep     (Ep),
        .Lm     (Lm),
        .CE     (CE),
        .Li     (Li),
        .Ei     (Ei),
        .La     (La),
        .Ea     (Ea),
        .Su     (Su),
        .Eu     (Eu),
        .Lb     (Lb),
        .Lo     (Lo),
        .hlt    (hlt),
        .tstate (tstate)
    );

    assign ctrl_obs = {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Instruction length in T-states for a non-halting opcode.
    function automatic int instr_len(input logic [3:0] op);
`ifdef CTRL_EARLY_RETURN_EN
        if (op == 4'h0) return 5;
        if (op == 4'h1 || op == 4'h2) return 6;
        return 4;
`else
        return 6;
`endif
    endfunction

    // Control word for T-state t while executing op.
    function automatic logic [11:0] exp_ctrl(input int t, input logic [3:0] op);
        logic [11:0] w;
        w = '0;
        if (t == 1) begin w[EP] = 1'b1; w[LM] = 1'b1; end
        if (t == 2) w[CP] = 1'b1;
        if (t == 3) begin w[CEB] = 1'b1; w[LI] = 1'b1; end
        if (op == 4'h0) begin
            if (t == 4) begin w[EI] = 1'b1; w[LM] = 1'b1; end
            if (t == 5) begin w[CEB] = 1'b1; w[LA] = 1'b1; end
        end
        if (op == 4'h1 || op == 4'h2) begin
            if (t == 4) begin w[EI] = 1'b1; w[LM] = 1'b1; end
            if (t == 5) begin w[CEB] = 1'b1; w[LB] = 1'b1; end
            if (t == 6) begin w[EU] = 1'b1; w[LA] = 1'b1; w[SU] = (op == 4'h2); end
        end
        if (op == 4'hE && t == 4) begin w[EA] = 1'b1; w[LO] = 1'b1; end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        logic [11:0] ec;
        logic        eh;
        logic [5:0]  et;
        if (clr) begin
            ec = '0;
            eh = 1'b0;
            et = 6'b000001;
        end else begin
            eh = halted_m || (t_m == 4 && opcode == 4'hF);
            ec = eh ? 12'h000 : exp_ctrl(t_m, opcode);
            et = 6'(1) << (t_m - 1);
        end
        chk({tag, "_tstate"}, {6'b0, tstate}, {6'b0, et});
        chk({tag, "_hlt"}, {11'b0, hlt}, {11'b0, eh});
        chk({tag, "_ctrl"}, ctrl_obs, ec);
    endtask

    task automatic model_step();
        if (halted_m) return;
        if (t_m == 4 && opcode == 4'hF) begin
            halted_m = 1'b1;
            return;
        end
        if (t_m >= 4 && t_m >= instr_len(opcode)) t_m = 1;
        else t_m = t_m + 1;
    endtask

    // One clock: drive opcode for the current state, check at the rising
    // edge, advance the model at the falling edge.
    task automatic do_cycle(input logic [3:0] op, input string tag);
        // opcode is don't-care in T2/T3 and while halted: scramble it there.
        if (halted_m || t_m == 2 || t_m == 3) opcode = 4'($urandom_range(0, 15));
        else opcode = op;
        @(posedge clk);
        #1;
        check_all(tag);
        if (Cp === 1'b1) cp_seen++;
        @(negedge clk);
        model_step();
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input string tag);
        int n;
        n = 0;
        cp_seen = 0;
        do begin
            do_cycle(op, tag);
            n++;
        end while (t_m != 1 && !halted_m && n < 8);
        if (!halted_m) chk({tag, "_cp_count"}, 12'(cp_seen), 12'd1);
    endtask

    initial begin
        logic [3:0] ops [4];
        logic [3:0] pick;
        ops[0] = 4'h0;
        ops[1] = 4'h1;
        ops[2] = 4'h2;
        ops[3] = 4'hE;

        // Reset held for two cycles.
        clr      = 1'b1;
        opcode   = 4'h0;
        t_m      = 1;
        halted_m = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all("reset");
        end
        @(negedge clk);
        #1;
        clr = 1'b0;
        #1;
        check_all("release_t1");

        run_instr(4'h0, "lda");
        run_instr(4'h1, "add");
        run_instr(4'h2, "sub");
        run_instr(4'hE, "out");
        run_instr(4'h7, "nop7");

        // Randomised instruction mix, including undefined opcodes 3..D.
        repeat (40) begin
            int k;
            k = $urandom_range(0, 4);
            if (k == 4) pick = 4'($urandom_range(3, 13));
            else pick = ops[k];
            run_instr(pick, "rand");
        end

        // Halt: sticky, counter frozen in T4.
        run_instr(4'hF, "hlt_enter");
        repeat (20) do_cycle(4'hF, "hlt_hold");

        clr      = 1'b1;
        t_m      = 1;
        halted_m = 1'b0;
        #1;
        check_all("hlt_clr");
        @(negedge clk);
        #1;
        clr = 1'b0;
        #1;
        check_all("hlt_restart");
        run_instr(4'h1, "post_hlt_add");

        // Asynchronous clr in the middle of LDA T5.
        opcode = 4'h0;
        while (t_m != 5) do_cycle(4'h0, "lda_to_t5");
        @(posedge clk);
        #1;
        check_all("lda_t5");
        #1;
        clr      = 1'b1;
        t_m      = 1;
        halted_m = 1'b0;
        #1;
        check_all("abort");
        chk("abort_la_ce", {10'b0, La, CE}, 12'b0);
        @(negedge clk);
        #1;
        clr = 1'b0;
        #1;
        check_all("abort_restart");
        run_instr(4'h2, "post_abort_sub");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
